// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants, opcodes and fetch FSM state type
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/npc_gen.sv
// rtl/npc_gen.sv - combinational next-PC selection: jump over taken beq over sequential
module npc_gen
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] ins,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] next_pc
);

    logic [31:0] br_off;

    assign br_off = {{14{ins[15]}}, ins[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], ins[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + br_off;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: PC, imem req/rvalid handshake, held instruction, retire count
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ins,
    output logic             ins_valid,
    input  logic             ins_ready,
    input  logic             branch,
    input  logic             jump,
    input  logic             zero,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  next_pc;

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q;

    npc_gen u_npc_gen (
        .pc_plus4 (pc_plus4),
        .ins      (ins),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc_q        <= PC_INIT;
            imem_req    <= 1'b0;
            ins         <= 32'd0;
            ins_valid   <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                // Leaving reset lands in FETCH with imem_req low; the first
                // edge raises it so the request pulse is still one registered cycle.
                FETCH: begin
                    if (imem_req) begin
                        imem_req <= 1'b0;
                        state    <= WAIT;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        ins       <= imem_rdata;
                        ins_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (ins_ready) begin
                        pc_q        <= next_pc;
                        instr_count <= instr_count + CNT_W'(1);
                        ins_valid   <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state    <= FETCH;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the MIPS core. Sits directly upstream of the main decoder and ALU control.
- Holds the PC, issues word reads to instruction memory over a req/rvalid handshake, and presents the 32-bit instruction (ins[31:26] → decoder opcode, ins[5:0] → ALU-control funct).
- Retires the instruction on downstream ready and computes next PC from decoder Branch/PCSrc and ALU zero.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] forced to 0.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active low.
- imem_req  out  1  single-cycle read request pulse.
- imem_addr  out  32  word address (= pc); valid when imem_req=1.
- imem_rvalid  in  1  read data valid; earliest the cycle after imem_req.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- ins  out  32  held instruction.
- ins_valid  out  1  ins/pc valid for execution.
- ins_ready  in  1  downstream executes/retires ins this cycle.
- branch  in  1  decoder Branch (beq).
- jump  in  1  decoder PCSrc (j).
- zero  in  1  ALU zero flag.
- pc  out  32  address of ins.
- pc_plus4  out  32  pc+4, for link/branch use.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: clk and rst_n only; synchronous, active low. While rst_n=0 on an edge:
  - pc=RESET_PC, state=FETCH
  - imem_req=0, ins=0, ins_valid=0, instr_count=0
  - Reset mid-operation (any state) abandons the outstanding fetch.
- States: FETCH, WAIT, HOLD.
  - FETCH: imem_req=1, imem_addr=pc for exactly this cycle → WAIT. imem_rvalid is ignored in FETCH.
  - WAIT: imem_req=0. On imem_rvalid: ins<=imem_rdata, → HOLD. Otherwise remain; no timeout.
  - HOLD: ins_valid=1. ins and pc are stable while ins_ready=0 (stall, no new request). On ins_ready=1: pc<=next_pc, instr_count+=1 (wraps mod 2^CNT_W), → FETCH. ins_valid is deasserted from the next cycle.
- imem_rvalid outside WAIT is a spurious response: ignored, no state change. Memory is required to drop in-flight responses on reset; a late rvalid arriving in FETCH is ignored.
- next_pc is combinational, sampled on the retiring edge. Priority:
  1. jump=1 → {pc_plus4[31:28], ins[25:0], 2'b00}
  2. else branch&zero → pc_plus4 + (sign_extend(ins[15:0]) << 2)
  3. else pc_plus4
- Arithmetic: all 32-bit, modulo 2^32; pc 0xFFFF_FFFC + 4 wraps to 0. pc[1:0] is always 00.
- branch, jump and zero are don't-care unless ins_valid&ins_ready. Simultaneous jump and branch: jump wins.
- Throughput: minimum 3 cycles/instruction (FETCH, WAIT with immediate rvalid, HOLD with ready).
- pc_plus4 = pc+4 always; it is valid whenever ins_valid=1.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants OP_RTYPE=6'b000000, OP_J=6'b000010, OP_BEQ=6'b000100, OP_ADDI=6'b001000, OP_LW=6'b100011, OP_SW=6'b101011.
  - fetch_state_t enum {FETCH, WAIT, HOLD}.
  - Default RESET_PC.
- One sub-module: npc_gen, combinational next-PC (pc_plus4, ins, branch, zero, jump → next_pc). It is reused by the verification reference model.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release → imem_req=1 with imem_addr=0x0 on the first cycle after release. During reset ins_valid=0, ins=0, instr_count=0.
- Sequential: memory 1-cycle latency returns 0x20080005 for every address, ins_ready=1 → pc sequence 0x0, 0x4, 0x8; ins_valid high every 3rd cycle; instr_count=3 after 9 cycles.
- Branch: ins=0x1000FFFF at pc=0x10, branch=1.
  - zero=1 → next fetch addr 0x10.
  - zero=0 → 0x14.
  - ins=0x10000003, zero=1 → 0x20.
- Jump: pc=0x9000_0000, ins=0x08000040, jump=1, branch=1, zero=1 → next addr 0x9000_0100 (jump priority).
- Stall and latency:
  - ins_ready=0 for 5 cycles → ins/pc constant, no imem_req.
  - rvalid latency of 4 cycles → exactly one imem_req pulse, ins captured on the rvalid edge.
  - Spurious rvalid in HOLD → ignored.
- Reset mid-WAIT, then late rvalid with 0xDEADBEEF in FETCH → ignored; refetch at RESET_PC; ins_valid stays 0 until the new response.
